// File: rtl/backoff_cnt_bank_if.sv
// backoff_cnt_bank_if: tx result / grant bundle between
// the MAC controller (master) and the backoff bank (slave).
interface backoff_cnt_bank_if #(
  parameter int NUM_AC = 4
);
  localparam int AW = (NUM_AC > 1) ? $clog2(NUM_AC) : 1;

  logic [AW-1:0]     txAc;
  logic              txSuccessful_p;
  logic              txFailed_p;
  logic [NUM_AC-1:0] retryLtReached;
  logic [NUM_AC-1:0] txGrant;
  logic [NUM_AC-1:0] internalColl_p;

  modport master (
    output txAc,
    output txSuccessful_p,
    output txFailed_p,
    output retryLtReached,
    input  txGrant,
    input  internalColl_p
  );

  modport slave (
    input  txAc,
    input  txSuccessful_p,
    input  txFailed_p,
    input  retryLtReached,
    output txGrant,
    output internalColl_p
  );
endinterface

// File: rtl/backoff_cnt_bank.sv
// backoff_cnt_bank: per-AC EDCA backoff counters with internal
// collision arbitration. Option: BACKOFF_AUTO_RELOAD_EN.
module backoff_cnt_bank #(
  parameter int NUM_AC     = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int PRNG_WIDTH = 19,
  parameter int BACKOFFOFF = 0,
  parameter int RND_STRIDE = 3,
  parameter int CWRESET    = 5
) (
  input  logic                        macCoreClk,
  input  logic                        macCoreClkHardRst_n,
  input  logic                        macCoreClkSoftRst_n,
  input  logic [PRNG_WIDTH-1:0]       pseudoRandomNumber,
  input  logic [NUM_AC-1:0]           backoffCntLoad,
  input  logic [NUM_AC-1:0]           backoffCntEnable,
  input  logic                        tickSlot_p,
  backoff_cnt_bank_if.slave           tx,
  input  logic                        currentStateEvent,
  input  logic [4*NUM_AC-1:0]         cwMin,
  input  logic [4*NUM_AC-1:0]         cwMax,
  input  logic [2*NUM_AC-1:0]         backoffOffset,
  output logic [CNT_WIDTH*NUM_AC-1:0] backoffCntValue,
  output logic [4*NUM_AC-1:0]         currentCW,
  output logic [NUM_AC-1:0]           backoffExpired
);
  localparam int AW = (NUM_AC > 1) ? $clog2(NUM_AC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_EXP   = 2'd2
  } st_e;

  st_e                  st_q  [NUM_AC];
  st_e                  st_d  [NUM_AC];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_AC];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_AC];
  logic [3:0]           cw_q  [NUM_AC];
  logic [3:0]           cw_d  [NUM_AC];
  logic [14:0]          rot   [NUM_AC];

  logic [NUM_AC-1:0] rld_q, rld_d;
  logic [NUM_AC-1:0] grant_q, grant_d;
  logic [NUM_AC-1:0] coll_q, coll_d;
  logic [NUM_AC-1:0] exp_v, res_v;
  logic [NUM_AC-1:0] succ_v, fail_v;
  logic [NUM_AC-1:0] win_v;

  // Per-channel rotated view of the PRNG; bit k is slice bit k.
  for (genvar g = 0; g < NUM_AC; g++) begin : g_rot
    for (genvar k = 0; k < 15; k++) begin : g_bit
      localparam int IX =
        (BACKOFFOFF + g * RND_STRIDE + k) % PRNG_WIDTH;
      assign rot[g][k] = pseudoRandomNumber[IX];
    end
  end

  function automatic logic [CNT_WIDTH-1:0] ld_val(
    input logic [14:0] r,
    input logic [3:0]  w,
    input logic [1:0]  off
  );
    logic [15:0] m;
    m = (16'd1 << w) - 16'd1;
    return CNT_WIDTH'(r & m[14:0]) + CNT_WIDTH'(off);
  endfunction

  // Decode tx results and arbitrate among expired channels.
  always_comb begin
    exp_v  = '0;
    res_v  = '0;
    succ_v = '0;
    fail_v = '0;
    win_v  = '0;
    coll_d = '0;
    for (int i = 0; i < NUM_AC; i++) begin
      exp_v[i]  = (st_q[i] == S_EXP);
      res_v[i]  = (tx.txSuccessful_p | tx.txFailed_p)
                  & (tx.txAc == AW'(i));
      succ_v[i] = tx.txSuccessful_p & (tx.txAc == AW'(i));
      fail_v[i] = tx.txFailed_p & (tx.txAc == AW'(i));
    end
    if (grant_q == '0) begin
      for (int i = 0; i < NUM_AC; i++) begin
        if (exp_v[i]) begin
          win_v    = '0;
          win_v[i] = 1'b1;
        end
      end
      coll_d = exp_v & ~win_v;
    end
    grant_d = (grant_q & ~res_v) | win_v;
  end

  // Contention window update, highest priority first.
  always_comb begin
    for (int i = 0; i < NUM_AC; i++) begin
      cw_d[i] = cw_q[i];
      if (currentStateEvent) begin
        cw_d[i] = cwMin[4*i +: 4];
      end else if (succ_v[i] | tx.retryLtReached[i]) begin
        cw_d[i] = cwMin[4*i +: 4];
      end else if (fail_v[i] | coll_d[i]) begin
        if (cw_q[i] >= cwMax[4*i +: 4])
          cw_d[i] = cwMax[4*i +: 4];
        else
          cw_d[i] = cw_q[i] + 4'd1;
      end
    end
  end

  // Per-channel next state and counter value.
  always_comb begin
    for (int i = 0; i < NUM_AC; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      rld_d[i] = 1'b0;
      unique case (st_q[i])
        S_IDLE: begin
          if (backoffCntLoad[i]) begin
            st_d[i]  = S_COUNT;
            cnt_d[i] = ld_val(rot[i], cw_q[i],
                              backoffOffset[2*i +: 2]);
          end
        end
        S_COUNT: begin
          if (backoffCntLoad[i] | rld_q[i]) begin
            cnt_d[i] = ld_val(rot[i], cw_q[i],
                              backoffOffset[2*i +: 2]);
          end else if (cnt_q[i] == '0) begin
            st_d[i] = S_EXP;
          end else if (backoffCntEnable[i] & tickSlot_p) begin
            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
          end
        end
        S_EXP: begin
          if (coll_d[i]) begin
            st_d[i]  = S_COUNT;
            cnt_d[i] = ld_val(rot[i], cw_d[i],
                              backoffOffset[2*i +: 2]);
          end else if (grant_q[i] & res_v[i]) begin
`ifdef BACKOFF_AUTO_RELOAD_EN
            st_d[i]  = S_COUNT;
            rld_d[i] = 1'b1;
`else
            st_d[i]  = S_IDLE;
`endif
          end
        end
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  // Drive the packed status outputs from registered state.
  always_comb begin
    backoffCntValue = '0;
    currentCW       = '0;
    backoffExpired  = '0;
    for (int i = 0; i < NUM_AC; i++) begin
      backoffCntValue[CNT_WIDTH*i +: CNT_WIDTH] = cnt_q[i];
      currentCW[4*i +: 4] = cw_q[i];
      backoffExpired[i]   = (st_q[i] == S_EXP);
    end
    tx.txGrant        = grant_q;
    tx.internalColl_p = coll_q;
  end

  // State registers; soft reset mirrors hard reset.
  always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
    if (!macCoreClkHardRst_n) begin
      for (int i = 0; i < NUM_AC; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
        cw_q[i]  <= 4'(CWRESET);
      end
      rld_q   <= '0;
      grant_q <= '0;
      coll_q  <= '0;
    end else if (!macCoreClkSoftRst_n) begin
      for (int i = 0; i < NUM_AC; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
        cw_q[i]  <= 4'(CWRESET);
      end
      rld_q   <= '0;
      grant_q <= '0;
      coll_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_AC; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        cw_q[i]  <= cw_d[i];
      end
      rld_q   <= rld_d;
      grant_q <= grant_d;
      coll_q  <= coll_d;
    end
  end
endmodule
